// File: rtl/pacman_video_pkg.sv
// pacman_video_pkg: shared 640x480 VGA timing defaults and the vblank update FSM state type.
package pacman_video_pkg;
    localparam int H_VISIBLE_AREA = 640;
    localparam int H_FRONT_PORCH  = 16;
    localparam int H_SYNC_PULSE   = 96;
    localparam int H_BACK_PORCH   = 48;
    localparam int V_VISIBLE_AREA = 480;
    localparam int V_FRONT_PORCH  = 10;
    localparam int V_SYNC_PULSE   = 2;
    localparam int V_BACK_PORCH   = 33;
    localparam int H_TOTAL = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int H_ADDR_WIDTH = $clog2(H_TOTAL);
    localparam int V_ADDR_WIDTH = $clog2(V_TOTAL);

    typedef enum logic [1:0] {IDLE, REQ, COMMIT} upd_state_t;
endpackage

// File: rtl/vga_frame_events.sv
// vga_frame_events: combinational vblank-start and frame-start strobes decoded from beam coordinates.
module vga_frame_events #(
    parameter int H_ADDR_WIDTH   = pacman_video_pkg::H_ADDR_WIDTH,
    parameter int V_ADDR_WIDTH   = pacman_video_pkg::V_ADDR_WIDTH,
    parameter int V_VISIBLE_AREA = pacman_video_pkg::V_VISIBLE_AREA
) (
    input  logic                    pix_clk,
    input  logic                    rst,
    input  logic [H_ADDR_WIDTH-1:0] sx,
    input  logic [V_ADDR_WIDTH-1:0] sy,
    output logic                    vb_start,
    output logic                    fr_start
);
    // Clock and reset are part of the shared port shape; the decode itself needs neither.
    logic unused_clk_rst;
    assign unused_clk_rst = pix_clk ^ rst;

    assign vb_start = (sx == '0) && (sy == V_ADDR_WIDTH'(V_VISIBLE_AREA));
    assign fr_start = (sx == '0) && (sy == '0);
endmodule

// File: rtl/vblank_update_sequencer.sv
// vblank_update_sequencer: walks update slots via req/ack during vblank, then pulses commit;
// also keeps the frame counter, animation phase and sticky overrun/timeout flags.
module vblank_update_sequencer #(
    parameter int H_VISIBLE_AREA = pacman_video_pkg::H_VISIBLE_AREA,
    parameter int H_FRONT_PORCH  = pacman_video_pkg::H_FRONT_PORCH,
    parameter int H_SYNC_PULSE   = pacman_video_pkg::H_SYNC_PULSE,
    parameter int H_BACK_PORCH   = pacman_video_pkg::H_BACK_PORCH,
    parameter int V_VISIBLE_AREA = pacman_video_pkg::V_VISIBLE_AREA,
    parameter int V_FRONT_PORCH  = pacman_video_pkg::V_FRONT_PORCH,
    parameter int V_SYNC_PULSE   = pacman_video_pkg::V_SYNC_PULSE,
    parameter int V_BACK_PORCH   = pacman_video_pkg::V_BACK_PORCH,
    parameter int N_SLOTS        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ANIM_DIV       = 8,
    localparam int H_ADDR_WIDTH  = $clog2(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH),
    localparam int V_ADDR_WIDTH  = $clog2(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH),
    localparam int SLOT_W        = $clog2(N_SLOTS)
) (
    input  logic                    pix_clk,
    input  logic                    rst,
    input  logic [H_ADDR_WIDTH-1:0] sx,
    input  logic [V_ADDR_WIDTH-1:0] sy,
    output logic                    upd_req,
    output logic [SLOT_W-1:0]       upd_slot,
    input  logic                    upd_ack,
    output logic                    commit,
    output logic                    busy,
    output logic [7:0]              frame_cnt,
    output logic                    anim_phase,
    output logic                    err_overrun,
    output logic                    err_timeout,
    input  logic                    clear_err
);
    import pacman_video_pkg::*;

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DIV_W = $clog2(ANIM_DIV + 1);

    upd_state_t        state, state_nx;
    logic [SLOT_W-1:0] slot, slot_nx;
    logic [TO_W-1:0]   wait_cnt, wait_nx;
    logic [DIV_W-1:0]  anim_div;
    logic              vb_start, fr_start, timed_out, div_wrap, set_to, set_ov;

    vga_frame_events #(
        .H_ADDR_WIDTH  (H_ADDR_WIDTH),
        .V_ADDR_WIDTH  (V_ADDR_WIDTH),
        .V_VISIBLE_AREA(V_VISIBLE_AREA)
    ) u_events (
        .pix_clk (pix_clk),
        .rst     (rst),
        .sx      (sx),
        .sy      (sy),
        .vb_start(vb_start),
        .fr_start(fr_start)
    );

    assign timed_out = wait_cnt == TO_W'(TIMEOUT_CYCLES - 1);
    assign div_wrap  = anim_div == DIV_W'(ANIM_DIV - 1);

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            state       <= IDLE;
            slot        <= '0;
            wait_cnt    <= '0;
            anim_div    <= '0;
            frame_cnt   <= '0;
            anim_phase  <= 1'b0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state    <= state_nx;
            slot     <= slot_nx;
            wait_cnt <= wait_nx;
            if (vb_start) begin
                frame_cnt  <= frame_cnt + 8'd1;
                anim_div   <= div_wrap ? '0 : anim_div + 1'b1;
                anim_phase <= anim_phase ^ div_wrap;
            end
            // A new error in the same cycle as clear_err must not be lost.
            err_overrun <= set_ov | (err_overrun & ~clear_err);
            err_timeout <= set_to | (err_timeout & ~clear_err);
        end
    end

    always_comb begin
        state_nx = state;
        slot_nx  = slot;
        wait_nx  = wait_cnt;
        set_to   = 1'b0;
        set_ov   = 1'b0;
        if (state == IDLE) begin
            if (vb_start) begin
                state_nx = REQ;
                slot_nx  = '0;
                wait_nx  = '0;
            end
        end else if (state == COMMIT) begin
            state_nx = IDLE;
        end else if (fr_start) begin
            // Visible frame began before all slots were updated: abandon without commit.
            state_nx = IDLE;
            set_ov   = 1'b1;
        end else if (upd_ack || timed_out) begin
            set_to   = ~upd_ack;
            state_nx = (slot == SLOT_W'(N_SLOTS - 1)) ? COMMIT : REQ;
            slot_nx  = slot + 1'b1;
            wait_nx  = '0;
        end else begin
            wait_nx = wait_cnt + 1'b1;
        end
    end

    assign upd_req  = state == REQ;
    assign upd_slot = upd_req ? slot : '0;
    assign commit   = state == COMMIT;
    assign busy     = state != IDLE;
endmodule

// File: tb/tb_vblank_update_sequencer.sv
// tb_vblank_update_sequencer: directed scenarios plus a randomized run against a slot-position model.
module tb_vblank_update_sequencer;
    localparam int N_SLOTS = 4;
    localparam int TO      = 8;
    localparam int ANIM    = 8;

    logic       pix_clk = 1'b0;
    logic       rst = 1'b1, upd_ack = 1'b0, clear_err = 1'b0;
    logic [9:0] sx = 10'd10, sy = 10'd100;
    logic       upd_req, commit, busy, anim_phase, err_overrun, err_timeout;
    logic [1:0] upd_slot;
    logic [7:0] frame_cnt;
    int         n_pass = 0, n_chk = 0;

    vblank_update_sequencer #(.N_SLOTS(N_SLOTS), .TIMEOUT_CYCLES(TO), .ANIM_DIV(ANIM)) dut (
        .pix_clk(pix_clk), .rst(rst), .sx(sx), .sy(sy),
        .upd_req(upd_req), .upd_slot(upd_slot), .upd_ack(upd_ack),
        .commit(commit), .busy(busy), .frame_cnt(frame_cnt), .anim_phase(anim_phase),
        .err_overrun(err_overrun), .err_timeout(err_timeout), .clear_err(clear_err)
    );

    always #5 pix_clk = ~pix_clk;

    // Model: m_pos is -1 when idle, 0..N_SLOTS-1 while requesting that slot, N_SLOTS while committing.
    int  m_pos = -1, m_wait = 0, m_frames = 0;
    bit  m_ov = 1'b0, m_to = 1'b0;
    wire m_vb     = (sx == 10'd0) && (sy == 10'd480);
    wire m_fr     = (sx == 10'd0) && (sy == 10'd0);
    wire in_req   = (m_pos >= 0) && (m_pos < N_SLOTS);
    wire m_abort  = in_req && m_fr;
    wire m_due    = upd_ack || (m_wait == TO - 1);
    wire m_expire = in_req && !m_fr && !upd_ack && (m_wait == TO - 1);

    always @(posedge pix_clk) begin
        if (rst) begin
            m_pos <= -1; m_wait <= 0; m_frames <= 0; m_ov <= 1'b0; m_to <= 1'b0;
        end else begin
            m_frames <= m_frames + (m_vb ? 1 : 0);
            if (m_pos < 0) begin
                if (m_vb) begin m_pos <= 0; m_wait <= 0; end
            end else if (m_pos == N_SLOTS || m_abort) m_pos <= -1;
            else if (m_due) begin m_pos <= m_pos + 1; m_wait <= 0; end
            else m_wait <= m_wait + 1;
            m_ov <= m_abort || (m_ov && !clear_err);
            m_to <= m_expire || (m_to && !clear_err);
        end
    end

    logic [15:0] dut_vec, exp_vec;
    assign dut_vec = {upd_req, upd_slot, commit, busy, frame_cnt, anim_phase, err_overrun, err_timeout};
    assign exp_vec = {in_req, in_req ? 2'(m_pos) : 2'd0, m_pos == N_SLOTS, m_pos >= 0,
                      8'(m_frames % 256), 1'((m_frames / ANIM) % 2), m_ov, m_to};

    task automatic step; @(posedge pix_clk); #1; endtask
    task automatic beam_neutral; sx = 10'd10; sy = 10'd100; endtask
    task automatic beam_vb; sx = 10'd0; sy = 10'd480; endtask
    task automatic beam_fr; sx = 10'd0; sy = 10'd0; endtask

    task automatic test_reset;
        rst = 1'b1; beam_neutral; step; step;
        n_chk++; if (dut_vec !== 16'h0) $display("FAIL reset_outputs: got %h want 0000", dut_vec); else n_pass++;
        rst = 1'b0; step;
        n_chk++; if (dut_vec !== 16'h0) $display("FAIL idle_after_reset: got %h want 0000", dut_vec); else n_pass++;
    endtask

    task automatic test_normal;
        int commits = 0;
        beam_vb; step; beam_neutral;
        for (int k = 0; k < N_SLOTS; k++) begin
            n_chk++;
            if ({upd_req, upd_slot, busy, commit} !== {1'b1, 2'(k), 1'b1, 1'b0})
                $display("FAIL normal_req%0d: got req=%b slot=%0d busy=%b commit=%b want 1 %0d 1 0", k, upd_req, upd_slot, busy, commit, k);
            else n_pass++;
            step; step; upd_ack = 1'b1; step; upd_ack = 1'b0;
        end
        n_chk++; if ({commit, busy, upd_req} !== 3'b110) $display("FAIL normal_commit: got %b want 110", {commit, busy, upd_req}); else n_pass++;
        n_chk++; if (frame_cnt !== 8'd1) $display("FAIL normal_frame_cnt: got %0d want 1", frame_cnt); else n_pass++;
        repeat (4) begin step; commits += int'(commit); end
        n_chk++; if ({busy, commits, err_timeout, err_overrun} !== {1'b0, 0, 1'b0, 1'b0})
            $display("FAIL normal_done: got busy=%b extra_commits=%0d to=%b ov=%b want 0 0 0 0", busy, commits, err_timeout, err_overrun);
        else n_pass++;
    endtask

    task automatic test_timeout;
        beam_vb; step; beam_neutral; upd_ack = 1'b1; step; upd_ack = 1'b0;
        repeat (7) step;
        n_chk++; if ({upd_slot, err_timeout} !== {2'd1, 1'b0}) $display("FAIL timeout_before: got slot=%0d to=%b want 1 0", upd_slot, err_timeout); else n_pass++;
        step;
        n_chk++; if ({upd_req, upd_slot, err_timeout} !== {1'b1, 2'd2, 1'b1}) $display("FAIL timeout_fired: got req=%b slot=%0d to=%b want 1 2 1", upd_req, upd_slot, err_timeout); else n_pass++;
        upd_ack = 1'b1; step; step; upd_ack = 1'b0;
        n_chk++; if (commit !== 1'b1) $display("FAIL timeout_commit: got %b want 1", commit); else n_pass++;
        step; clear_err = 1'b1; step; clear_err = 1'b0;
        n_chk++; if (err_timeout !== 1'b0) $display("FAIL timeout_clear: got %b want 0", err_timeout); else n_pass++;
    endtask

    task automatic test_overrun;
        int commits = 0;
        beam_vb; step; beam_neutral; upd_ack = 1'b1; step; step; upd_ack = 1'b0; step; step;
        n_chk++; if (upd_slot !== 2'd2) $display("FAIL overrun_slot: got %0d want 2", upd_slot); else n_pass++;
        beam_fr; step; beam_neutral;
        n_chk++; if ({upd_req, busy, commit, err_overrun} !== 4'b0001) $display("FAIL overrun_abort: got %b want 0001", {upd_req, busy, commit, err_overrun}); else n_pass++;
        repeat (10) begin step; commits += int'(commit); end
        n_chk++; if ({commits, err_timeout} !== {0, 1'b0}) $display("FAIL overrun_no_commit: got commits=%0d to=%b want 0 0", commits, err_timeout); else n_pass++;
        beam_vb; step; beam_neutral;
        n_chk++; if ({upd_req, upd_slot} !== {1'b1, 2'd0}) $display("FAIL overrun_restart: got req=%b slot=%0d want 1 0", upd_req, upd_slot); else n_pass++;
        beam_fr; step; beam_neutral; clear_err = 1'b1; step; clear_err = 1'b0;
        n_chk++; if ({busy, err_overrun} !== 2'b00) $display("FAIL overrun_clear: got busy=%b ov=%b want 0 0", busy, err_overrun); else n_pass++;
    endtask

    task automatic test_ack_fr;
        beam_vb; step; beam_neutral; upd_ack = 1'b1; step; step; step;
        beam_fr; step; beam_neutral; upd_ack = 1'b0;
        n_chk++; if ({commit, upd_req, busy, err_overrun} !== 4'b0001) $display("FAIL ackfr_abort: got %b want 0001", {commit, upd_req, busy, err_overrun}); else n_pass++;
        step;
        n_chk++; if (commit !== 1'b0) $display("FAIL ackfr_no_commit: got %b want 0", commit); else n_pass++;
        clear_err = 1'b1; step; clear_err = 1'b0;
    endtask

    task automatic test_anim_wrap;
        rst = 1'b1; step; rst = 1'b0; beam_vb;
        for (int f = 1; f <= 300; f++) begin
            step;
            n_chk++;
            if ({frame_cnt, anim_phase} !== {8'(f % 256), 1'((f / ANIM) % 2)})
                $display("FAIL anim_frame%0d: got cnt=%0d phase=%b want %0d %0d", f, frame_cnt, anim_phase, f % 256, (f / ANIM) % 2);
            else n_pass++;
        end
        beam_neutral; rst = 1'b1; step; rst = 1'b0;
    endtask

    task automatic test_rst_mid;
        int commits = 0;
        beam_vb; step; beam_neutral; upd_ack = 1'b1; step; upd_ack = 1'b0;
        n_chk++; if (upd_slot !== 2'd1) $display("FAIL rstmid_slot: got %0d want 1", upd_slot); else n_pass++;
        rst = 1'b1; step; rst = 1'b0;
        n_chk++; if (dut_vec !== 16'h0) $display("FAIL rstmid_outputs: got %h want 0000", dut_vec); else n_pass++;
        repeat (5) begin step; commits += int'(commit); end
        n_chk++; if (commits !== 0) $display("FAIL rstmid_no_commit: got %0d want 0", commits); else n_pass++;
        beam_vb; step; beam_neutral; repeat (7) step;
        clear_err = 1'b1; step; clear_err = 1'b0;
        n_chk++; if ({err_timeout, upd_slot} !== {1'b1, 2'd1}) $display("FAIL clear_vs_timeout: got to=%b slot=%0d want 1 1", err_timeout, upd_slot); else n_pass++;
        step;
        n_chk++; if (err_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", err_timeout); else n_pass++;
        rst = 1'b1; step; rst = 1'b0;
    endtask

    task automatic test_random;
        int r;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) beam_vb;
            else if (r < 7) beam_fr;
            else begin sx = 10'($urandom_range(1, 799)); sy = 10'($urandom_range(0, 524)); end
            upd_ack   = ($urandom_range(0, 2) == 0);
            clear_err = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            step;
            n_chk++;
            if (dut_vec !== exp_vec) $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec, exp_vec);
            else n_pass++;
        end
        rst = 1'b0; upd_ack = 1'b0; clear_err = 1'b0; beam_neutral;
    endtask

    initial begin
        test_reset;
        test_normal;
        test_timeout;
        test_overrun;
        test_ack_fr;
        test_anim_wrap;
        test_rst_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vblank_update_sequencer.md
Name: vblank_update_sequencer

Overview:
- Schedules per-frame game-state updates so the pixel datapath never sees half-updated sprite positions.
- On entry to vertical blanking it walks N_SLOTS sprite/update slots through a req/ack handshake with game logic, then issues one commit pulse that swaps the drawing registers.
- It also keeps the frame counter and animation phase used by the drawing logic.
- It sits beside the drawing logic on pix_clk and consumes the same sx/sy beam coordinates.

Parameters:
- H_VISIBLE_AREA, 640, visible pixels per line
- H_FRONT_PORCH/H_SYNC_PULSE/H_BACK_PORCH, 16/96/48, horizontal timing
- V_VISIBLE_AREA, 480, visible lines
- V_FRONT_PORCH/V_SYNC_PULSE/V_BACK_PORCH, 10/2/33, vertical timing
- N_SLOTS, 4, update slots per frame (must be >=2)
- TIMEOUT_CYCLES, 1024, maximum pix_clk cycles waited for upd_ack per slot
- ANIM_DIV, 8, frames per anim_phase toggle (must be >=1)
- Derived localparams: H_ADDR_WIDTH=$clog2(H total), V_ADDR_WIDTH=$clog2(V total), SLOT_W=$clog2(N_SLOTS)

Ports:
- pix_clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- sx  in  H_ADDR_WIDTH  beam x
- sy  in  V_ADDR_WIDTH  beam y
- upd_req  out  1  update request for upd_slot
- upd_slot  out  SLOT_W  slot being requested
- upd_ack  in  1  one-cycle acknowledge from game logic
- commit  out  1  one-cycle pulse: all slots updated, swap registers
- busy  out  1  sequence in progress
- frame_cnt  out  8  frames since reset
- anim_phase  out  1  toggles every ANIM_DIV frames
- err_overrun  out  1  sticky: sequence aborted by start of the visible frame
- err_timeout  out  1  sticky: a slot exceeded TIMEOUT_CYCLES
- clear_err  in  1  clears both sticky flags

Behaviour:
- Interface: one clock (pix_clk); reset rst is synchronous, active-high.
- Reset values: all outputs 0. FSM state IDLE, slot 0, timeout counter 0, anim divider 0.
- Events, decoded combinationally from sx/sy:
  - vb_start = (sx==0 && sy==V_VISIBLE_AREA)
  - fr_start = (sx==0 && sy==0)
- Every vb_start cycle:
  - frame_cnt increments next cycle, wrapping 255->0.
  - anim divider increments. When it reaches ANIM_DIV-1 it resets to 0 and anim_phase toggles.
- FSM states: IDLE, REQ, COMMIT.
- IDLE:
  - On vb_start, go to REQ next cycle with slot=0 and timeout counter=0.
  - upd_ack is ignored in IDLE.
- REQ:
  - upd_req=1, upd_slot=slot, busy=1.
  - On upd_ack: if slot==N_SLOTS-1 go to COMMIT; else slot+1 and the counter clears. upd_req stays high with the new slot the next cycle.
  - With no ack, the counter increments. When it reaches TIMEOUT_CYCLES-1 without an ack, set err_timeout and advance exactly as if acked.
  - fr_start while in REQ: go to IDLE. upd_req drops next cycle, err_overrun is set, no commit.
  - fr_start and upd_ack in the same cycle: the abort wins and the ack is ignored.
- COMMIT: commit=1 for exactly one cycle, busy=1, then IDLE.
- vb_start while not in IDLE is ignored by the FSM. Counters still advance.
- Latency: upd_req rises 1 cycle after vb_start. commit follows 1 cycle after the final ack.
- Sticky flags:
  - clear_err clears both flags next cycle.
  - A set condition in the same cycle as clear_err wins, so the flag stays 1.
- Reset mid-sequence: rst returns to IDLE with upd_req=0 the next cycle. No commit is emitted.

Decomposition:
- Package pacman_video_pkg holds:
  - VGA timing defaults (640x480 values above) and the derived H/V address widths.
  - typedef enum logic [1:0] {IDLE, REQ, COMMIT} upd_state_t.
- Sub-module vga_frame_events:
  - Inputs: pix_clk, rst, sx, sy.
  - Outputs: vb_start, fr_start.
  - Reused by other frame-synchronous blocks.

Test Plan:
- Ack each slot 2 cycles after request (N_SLOTS=4, TIMEOUT_CYCLES=8):
  - upd_slot steps 0,1,2,3.
  - commit pulses once, 1 cycle after the 4th ack.
  - busy drops after commit; frame_cnt increments by 1.
- Never ack slot 1 (TIMEOUT_CYCLES=8):
  - After 8 cycles err_timeout=1 and upd_slot advances to 2.
  - commit still occurs after slot 3 is acked.
- Withhold ack on slot 2 until fr_start (large TIMEOUT_CYCLES):
  - upd_req=0 the next cycle, err_overrun=1, no commit.
  - Returns to IDLE; the next vb_start restarts at slot 0.
- upd_ack coincident with fr_start on the last slot: no commit, err_overrun=1.
- Run 17 frames with ANIM_DIV=8:
  - anim_phase toggles on the vb_start of frames 8 and 16.
  - frame_cnt=17; wrap 255->0 checked via force/preload.
- Assert rst while in REQ on slot 1: outputs 0 the next cycle, frame_cnt=0, no commit. Also assert clear_err together with a timeout: err_timeout remains 1.
